// File: rtl/jtag_tap_gen_pkg.sv
// Shared definitions for the jtag_tap_gen TAP controller:
//   - tap_state_e : 4-bit encoding of the 16 IEEE 1149.1 TAP states
//   - OP_*        : fixed instruction opcodes, zero-extended to IR_WIDTH where used
//   - next_state  : TAP state graph (state, tms) -> next state
package jtag_tap_gen_pkg;

  typedef enum logic [3:0] {
    ST_TLR      = 4'd0,
    ST_RTI      = 4'd1,
    ST_SEL_DR   = 4'd2,
    ST_CAP_DR   = 4'd3,
    ST_SHIFT_DR = 4'd4,
    ST_EXIT1_DR = 4'd5,
    ST_PAUSE_DR = 4'd6,
    ST_EXIT2_DR = 4'd7,
    ST_UPD_DR   = 4'd8,
    ST_SEL_IR   = 4'd9,
    ST_CAP_IR   = 4'd10,
    ST_SHIFT_IR = 4'd11,
    ST_EXIT1_IR = 4'd12,
    ST_PAUSE_IR = 4'd13,
    ST_EXIT2_IR = 4'd14,
    ST_UPD_IR   = 4'd15
  } tap_state_e;

  // BYPASS is all ones at any IR width: replicate this bit IR_WIDTH times.
  localparam logic       OP_BYPASS_LSB = 1'b1;
  localparam logic [2:0] OP_IDCODE     = 3'd1;
  localparam logic [2:0] OP_SAMPLE     = 3'd2;
  localparam logic [2:0] OP_PRELOAD    = 3'd3;
  localparam logic [2:0] OP_INTEST     = 3'd4;
  localparam logic [2:0] OP_EXTEST     = 3'd5;

  function automatic tap_state_e next_state(input tap_state_e state, input logic tms);
    tap_state_e nxt;
    nxt = ST_TLR;
    case (state)
      ST_TLR:      nxt = tms ? ST_TLR      : ST_RTI;
      ST_RTI:      nxt = tms ? ST_SEL_DR   : ST_RTI;
      ST_SEL_DR:   nxt = tms ? ST_SEL_IR   : ST_CAP_DR;
      ST_CAP_DR:   nxt = tms ? ST_EXIT1_DR : ST_SHIFT_DR;
      ST_SHIFT_DR: nxt = tms ? ST_EXIT1_DR : ST_SHIFT_DR;
      ST_EXIT1_DR: nxt = tms ? ST_UPD_DR   : ST_PAUSE_DR;
      ST_PAUSE_DR: nxt = tms ? ST_EXIT2_DR : ST_PAUSE_DR;
      ST_EXIT2_DR: nxt = tms ? ST_UPD_DR   : ST_SHIFT_DR;
      ST_UPD_DR:   nxt = tms ? ST_SEL_DR   : ST_RTI;
      ST_SEL_IR:   nxt = tms ? ST_TLR      : ST_CAP_IR;
      ST_CAP_IR:   nxt = tms ? ST_EXIT1_IR : ST_SHIFT_IR;
      ST_SHIFT_IR: nxt = tms ? ST_EXIT1_IR : ST_SHIFT_IR;
      ST_EXIT1_IR: nxt = tms ? ST_UPD_IR   : ST_PAUSE_IR;
      ST_PAUSE_IR: nxt = tms ? ST_EXIT2_IR : ST_PAUSE_IR;
      ST_EXIT2_IR: nxt = tms ? ST_UPD_IR   : ST_SHIFT_IR;
      ST_UPD_IR:   nxt = tms ? ST_SEL_DR   : ST_RTI;
      default:     nxt = ST_TLR;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/jtag_tap_fsm.sv
// TAP state register and state strobes.
//   tck, rst_n, tms : JTAG clock, async active-low reset, mode select
//   state           : current TAP state
//   tlr, capture_*, shift_*, update_* : high while in the matching state
// Returning to Test-Logic-Reset after five TMS=1 clocks is a property of the
// state graph itself; no separate counter exists.
module jtag_tap_fsm
  import jtag_tap_gen_pkg::*;
(
  input  logic       tck,
  input  logic       rst_n,
  input  logic       tms,
  output tap_state_e state,
  output logic       tlr,
  output logic       capture_dr,
  output logic       shift_dr,
  output logic       update_dr,
  output logic       capture_ir,
  output logic       shift_ir,
  output logic       update_ir
);

  tap_state_e state_q;
  tap_state_e state_d;

  always_comb begin
    state_d = next_state(state_q, tms);
  end

  always_ff @(posedge tck or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_TLR;
    end else begin
      state_q <= state_d;
    end
  end

  assign state      = state_q;
  assign tlr        = (state_q == ST_TLR);
  assign capture_dr = (state_q == ST_CAP_DR);
  assign shift_dr   = (state_q == ST_SHIFT_DR);
  assign update_dr  = (state_q == ST_UPD_DR);
  assign capture_ir = (state_q == ST_CAP_IR);
  assign shift_ir   = (state_q == ST_SHIFT_IR);
  assign update_ir  = (state_q == ST_UPD_IR);

endmodule

// File: rtl/jtag_tap_gen.sv
// Second-generation JTAG TAP controller, entirely in the tck domain.
//   tck, rst_n, tms, tdi      : JTAG pins (posedge: state/shift, negedge: update/TDO)
//   tdo, tdo_oe               : serial out (negedge registered) and its valid flag
//   bsr_capture_data          : parallel sample of DUT pins
//   bsr_update_data           : boundary update register
//   bsr_test_mode, bsr_intest : EXTEST/INTEST and INTEST-only decode
//   user_sel, user_capture/shift/update, user_tdo : external user DR chains
//   tap_state, instr          : current TAP state and updated instruction
module jtag_tap_gen
  import jtag_tap_gen_pkg::*;
#(
  parameter int unsigned          IR_WIDTH  = 5,
  parameter logic [31:0]          IDCODE    = 32'hDEADBEEF,
  parameter int unsigned          BSR_WIDTH = 7,
  parameter int unsigned          NUM_USER  = 2,
  parameter logic [IR_WIDTH-1:0]  USER_BASE = IR_WIDTH'(5'b01000)
) (
  input  logic                                      tck,
  input  logic                                      rst_n,
  input  logic                                      tms,
  input  logic                                      tdi,
  output logic                                      tdo,
  output logic                                      tdo_oe,
  input  logic [BSR_WIDTH-1:0]                      bsr_capture_data,
  output logic [BSR_WIDTH-1:0]                      bsr_update_data,
  output logic                                      bsr_test_mode,
  output logic                                      bsr_intest,
  output logic [((NUM_USER > 0) ? NUM_USER : 1)-1:0] user_sel,
  output logic                                      user_capture,
  output logic                                      user_shift,
  output logic                                      user_update,
  input  logic [((NUM_USER > 0) ? NUM_USER : 1)-1:0] user_tdo,
  output logic [3:0]                                tap_state,
  output logic [IR_WIDTH-1:0]                       instr
);

  localparam int unsigned UW = (NUM_USER > 0) ? NUM_USER : 1;

  localparam logic [IR_WIDTH-1:0] OPC_BYPASS  = {IR_WIDTH{OP_BYPASS_LSB}};
  localparam logic [IR_WIDTH-1:0] OPC_IDCODE  = IR_WIDTH'(OP_IDCODE);
  localparam logic [IR_WIDTH-1:0] OPC_SAMPLE  = IR_WIDTH'(OP_SAMPLE);
  localparam logic [IR_WIDTH-1:0] OPC_PRELOAD = IR_WIDTH'(OP_PRELOAD);
  localparam logic [IR_WIDTH-1:0] OPC_INTEST  = IR_WIDTH'(OP_INTEST);
  localparam logic [IR_WIDTH-1:0] OPC_EXTEST  = IR_WIDTH'(OP_EXTEST);

  typedef enum logic [1:0] {
    DR_BYPASS,
    DR_IDCODE,
    DR_BSR,
    DR_USER
  } dr_sel_e;

  tap_state_e state;
  logic       tlr;
  logic       capture_dr;
  logic       shift_dr;
  logic       update_dr;
  logic       capture_ir;
  logic       shift_ir;
  logic       update_ir;

  jtag_tap_fsm u_fsm (
    .tck        (tck),
    .rst_n      (rst_n),
    .tms        (tms),
    .state      (state),
    .tlr        (tlr),
    .capture_dr (capture_dr),
    .shift_dr   (shift_dr),
    .update_dr  (update_dr),
    .capture_ir (capture_ir),
    .shift_ir   (shift_ir),
    .update_ir  (update_ir)
  );

  // Posedge shift registers
  logic [IR_WIDTH-1:0]  ir_shift_q,  ir_shift_d;
  logic                 bypass_q,    bypass_d;
  logic [31:0]          idcode_q,    idcode_d;
  logic [BSR_WIDTH-1:0] bsr_shift_q, bsr_shift_d;

  // Negedge registers
  logic [IR_WIDTH-1:0]  instr_q,      instr_d;
  logic [BSR_WIDTH-1:0] bsr_update_q, bsr_update_d;
  logic                 tdo_q,        tdo_d;
  logic                 tdo_oe_q,     tdo_oe_d;

  // Instruction decode
  dr_sel_e       dr_sel;
  logic [UW-1:0] user_hit;
  logic [UW-1:0] user_sel_int;
  logic          dr_lsb;

  always_comb begin
    user_hit = '0;
    for (int unsigned i = 0; i < NUM_USER; i++) begin
      user_hit[i] = (instr_q == USER_BASE + IR_WIDTH'(i));
    end

    // Fixed opcodes take priority over user opcodes; anything unmatched is BYPASS.
    dr_sel = DR_BYPASS;
    if (instr_q == OPC_BYPASS) begin
      dr_sel = DR_BYPASS;
    end else if (instr_q == OPC_IDCODE) begin
      dr_sel = DR_IDCODE;
    end else if ((instr_q == OPC_SAMPLE) || (instr_q == OPC_PRELOAD) ||
                 (instr_q == OPC_INTEST) || (instr_q == OPC_EXTEST)) begin
      dr_sel = DR_BSR;
    end else if (|user_hit) begin
      dr_sel = DR_USER;
    end

    user_sel_int = (dr_sel == DR_USER) ? user_hit : '0;
  end

  always_comb begin
    dr_lsb = bypass_q;
    case (dr_sel)
      DR_BYPASS: dr_lsb = bypass_q;
      DR_IDCODE: dr_lsb = idcode_q[0];
      DR_BSR:    dr_lsb = bsr_shift_q[0];
      DR_USER:   dr_lsb = |(user_sel_int & user_tdo);
      default:   dr_lsb = bypass_q;
    endcase
  end

  // Only the register selected by the current instruction captures or shifts.
  always_comb begin
    ir_shift_d  = ir_shift_q;
    bypass_d    = bypass_q;
    idcode_d    = idcode_q;
    bsr_shift_d = bsr_shift_q;

    if (capture_ir) begin
      ir_shift_d = IR_WIDTH'(2'b01);
    end else if (shift_ir) begin
      ir_shift_d = (ir_shift_q >> 1) | (IR_WIDTH'(tdi) << (IR_WIDTH - 1));
    end

    case (dr_sel)
      DR_BYPASS: begin
        if (capture_dr) begin
          bypass_d = 1'b0;
        end else if (shift_dr) begin
          bypass_d = tdi;
        end
      end
      DR_IDCODE: begin
        if (capture_dr) begin
          idcode_d = IDCODE;
        end else if (shift_dr) begin
          idcode_d = {tdi, idcode_q[31:1]};
        end
      end
      DR_BSR: begin
        if (capture_dr) begin
          bsr_shift_d = bsr_capture_data;
        end else if (shift_dr) begin
          // Shift-and-or form keeps BSR_WIDTH == 1 legal.
          bsr_shift_d = (bsr_shift_q >> 1) | (BSR_WIDTH'(tdi) << (BSR_WIDTH - 1));
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge tck or negedge rst_n) begin
    if (!rst_n) begin
      ir_shift_q  <= '0;
      bypass_q    <= 1'b0;
      idcode_q    <= '0;
      bsr_shift_q <= '0;
    end else begin
      ir_shift_q  <= ir_shift_d;
      bypass_q    <= bypass_d;
      idcode_q    <= idcode_d;
      bsr_shift_q <= bsr_shift_d;
    end
  end

  // Falling-edge logic: instruction/boundary update and TDO launch, so that
  // outputs are stable across the following rising edge.
  always_comb begin
    instr_d      = instr_q;
    bsr_update_d = bsr_update_q;
    tdo_d        = tdo_q;
    tdo_oe_d     = shift_ir | shift_dr;

    if (tlr) begin
      instr_d = OPC_IDCODE;
    end else if (update_ir) begin
      instr_d = ir_shift_q;
    end

    if (update_dr && (dr_sel == DR_BSR)) begin
      bsr_update_d = bsr_shift_q;
    end

    if (shift_ir) begin
      tdo_d = ir_shift_q[0];
    end else if (shift_dr) begin
      tdo_d = dr_lsb;
    end
  end

  always_ff @(negedge tck or negedge rst_n) begin
    if (!rst_n) begin
      instr_q      <= OPC_IDCODE;
      bsr_update_q <= '0;
      tdo_q        <= 1'b0;
      tdo_oe_q     <= 1'b0;
    end else begin
      instr_q      <= instr_d;
      bsr_update_q <= bsr_update_d;
      tdo_q        <= tdo_d;
      tdo_oe_q     <= tdo_oe_d;
    end
  end

  assign tdo             = tdo_q;
  assign tdo_oe          = tdo_oe_q;
  assign instr           = instr_q;
  assign bsr_update_data = bsr_update_q;
  assign bsr_test_mode   = (instr_q == OPC_INTEST) || (instr_q == OPC_EXTEST);
  assign bsr_intest      = (instr_q == OPC_INTEST);
  assign tap_state       = state;
  assign user_sel        = user_sel_int;
  assign user_capture    = capture_dr & (dr_sel == DR_USER);
  assign user_shift      = shift_dr   & (dr_sel == DR_USER);
  assign user_update     = update_dr  & (dr_sel == DR_USER);

endmodule

// File: tb/tb_jtag_tap_gen.sv
// Randomized self-checking bench for jtag_tap_gen. A table-driven TAP graph and
// a stream-based scan model (captured bits followed by shifted-in bits) supply
// all expected values.
module tb_jtag_tap_gen;
  import jtag_tap_gen_pkg::*;

  localparam int unsigned IRW   = 5;
  localparam int unsigned BSRW  = 7;
  localparam int unsigned NU    = 2;
  localparam logic [4:0]  UBASE = 5'b01000;
  localparam logic [31:0] IDC   = 32'hDEADBEEF;

  logic            tck = 1'b0;
  logic            rst_n = 1'b0;
  logic            tms = 1'b1;
  logic            tdi = 1'b0;
  logic            tdo;
  logic            tdo_oe;
  logic [BSRW-1:0] bsr_capture_data = '0;
  logic [BSRW-1:0] bsr_update_data;
  logic            bsr_test_mode;
  logic            bsr_intest;
  logic [NU-1:0]   user_sel;
  logic            user_capture;
  logic            user_shift;
  logic            user_update;
  logic [NU-1:0]   user_tdo = '0;
  logic [3:0]      tap_state;
  logic [IRW-1:0]  instr;

  jtag_tap_gen #(
    .IR_WIDTH  (IRW),
    .IDCODE    (IDC),
    .BSR_WIDTH (BSRW),
    .NUM_USER  (NU),
    .USER_BASE (UBASE)
  ) dut (
    .tck              (tck),
    .rst_n            (rst_n),
    .tms              (tms),
    .tdi              (tdi),
    .tdo              (tdo),
    .tdo_oe           (tdo_oe),
    .bsr_capture_data (bsr_capture_data),
    .bsr_update_data  (bsr_update_data),
    .bsr_test_mode    (bsr_test_mode),
    .bsr_intest       (bsr_intest),
    .user_sel         (user_sel),
    .user_capture     (user_capture),
    .user_shift       (user_shift),
    .user_update      (user_update),
    .user_tdo         (user_tdo),
    .tap_state        (tap_state),
    .instr            (instr)
  );

  always #10 tck = ~tck;

  int n_pass  = 0;
  int n_total = 0;

  // Reference model state
  tap_state_e      nxt [16][2];
  tap_state_e      m_state;
  logic [IRW-1:0]  m_ir;
  logic [IRW-1:0]  m_instr;
  logic [BSRW-1:0] m_bsr_upd;
  logic [NU-1:0]   ut_drv;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  task automatic edge_def(input tap_state_e s, input tap_state_e on0, input tap_state_e on1);
    nxt[s][0] = on0;
    nxt[s][1] = on1;
  endtask

  // 0 = bypass, 1 = idcode, 2 = boundary scan, 3 = user chain
  function automatic int kind_of(input logic [IRW-1:0] op);
    int unsigned v;
    int unsigned ub;
    v  = op;
    ub = UBASE;
    if (v == (1 << IRW) - 1) return 0;
    if (v == 1) return 1;
    if (v >= 2 && v <= 5) return 2;
    if (v >= ub && v < ub + NU) return 3;
    return 0;
  endfunction

  task automatic tck_cycle(input logic tms_v, input logic tdi_v);
    int k;
    int unsigned uidx;
    logic [NU-1:0] exp_sel;
    bit sh;
    tms = tms_v;
    tdi = tdi_v;
    user_tdo = NU'($urandom);
    ut_drv = user_tdo;
    @(posedge tck);
    if (m_state == ST_CAP_IR) m_ir = IRW'(1);
    else if (m_state == ST_SHIFT_IR) m_ir = {tdi_v, m_ir[IRW-1:1]};
    m_state = nxt[m_state][tms_v];
    if (m_state == ST_UPD_IR) m_instr = m_ir;
    if (m_state == ST_TLR) m_instr = IRW'(1);
    @(negedge tck);
    #2;
    k = kind_of(m_instr);
    uidx = m_instr - UBASE;
    exp_sel = (k == 3) ? (NU'(1) << uidx) : '0;
    sh = (m_state == ST_SHIFT_DR) || (m_state == ST_SHIFT_IR);
    check_eq("state", tap_state, m_state);
    check_eq("tdo_oe", tdo_oe, sh);
    check_eq("instr", instr, m_instr);
    check_eq("test_mode", bsr_test_mode, (m_instr == 4) || (m_instr == 5));
    check_eq("intest", bsr_intest, m_instr == 4);
    check_eq("user_sel", user_sel, exp_sel);
    check_eq("user_capture", user_capture, (k == 3) && (m_state == ST_CAP_DR));
    check_eq("user_shift", user_shift, (k == 3) && (m_state == ST_SHIFT_DR));
    check_eq("user_update", user_update, (k == 3) && (m_state == ST_UPD_DR));
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_state"}, tap_state, ST_TLR);
    check_eq({tag, "_instr"}, instr, 1);
    check_eq({tag, "_tdo"}, tdo, 0);
    check_eq({tag, "_tdo_oe"}, tdo_oe, 0);
    check_eq({tag, "_bsr_upd"}, bsr_update_data, 0);
    check_eq({tag, "_test_mode"}, bsr_test_mode, 0);
    check_eq({tag, "_user_sel"}, user_sel, 0);
    check_eq({tag, "_user_strobes"}, {user_capture, user_shift, user_update}, 0);
  endtask

  task automatic model_reset();
    m_state   = ST_TLR;
    m_ir      = '0;
    m_instr   = IRW'(1);
    m_bsr_upd = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tms   = 1'b1;
    @(negedge tck);
    #2;
    check_reset_outputs("reset");
    #3;
    rst_n = 1'b1;
    model_reset();
  endtask

  // Full scan from Run-Test/Idle back to Run-Test/Idle. The serial output is
  // the captured value followed by the shifted-in bits; what remains in the
  // register afterwards is the window of that stream starting at bit n.
  task automatic scan(input bit is_ir, input int unsigned n, input logic [63:0] din,
                      input int unsigned pause_at, input logic [BSRW-1:0] cap);
    logic [127:0] stream;
    int unsigned  len;
    int           kind;
    int unsigned  oe_cnt;
    int unsigned  uidx;
    logic         exp_bit;
    bsr_capture_data = cap;
    kind = is_ir ? -1 : kind_of(m_instr);
    uidx = m_instr - UBASE;
    oe_cnt = 0;
    len = 0;
    stream = '0;
    if (is_ir) begin
      len = IRW;
      stream = 128'd1;
    end else begin
      case (kind)
        0: begin len = 1;    stream = '0; end
        1: begin len = 32;   stream = {96'b0, IDC}; end
        2: begin len = BSRW; stream = {{(128-BSRW){1'b0}}, cap}; end
        default: begin len = 0; stream = '0; end
      endcase
    end
    stream = stream | ({64'b0, din} << len);

    tck_cycle(1'b1, 1'($urandom));
    if (is_ir) tck_cycle(1'b1, 1'($urandom));
    tck_cycle(1'b0, 1'($urandom));
    tck_cycle(1'b0, 1'($urandom));
    oe_cnt += tdo_oe;
    exp_bit = (kind == 3) ? ut_drv[uidx] : stream[0];
    check_eq("tdo", tdo, exp_bit);

    for (int unsigned k = 0; k < n; k++) begin
      bit last;
      last = (k == n - 1);
      if (!last && k == pause_at) begin
        tck_cycle(1'b1, din[k]);
        oe_cnt += tdo_oe;
        repeat (1 + $urandom_range(0, 2)) begin
          tck_cycle(1'b0, 1'($urandom));
          oe_cnt += tdo_oe;
        end
        tck_cycle(1'b1, 1'($urandom));
        oe_cnt += tdo_oe;
        tck_cycle(1'b0, 1'($urandom));
      end else begin
        tck_cycle(last, din[k]);
      end
      oe_cnt += tdo_oe;
      if (!last) begin
        exp_bit = (kind == 3) ? ut_drv[uidx] : stream[k + 1];
        check_eq("tdo", tdo, exp_bit);
      end
    end

    tck_cycle(1'b1, 1'($urandom));
    check_eq("oe_count", oe_cnt, n);
    if (is_ir) begin
      check_eq("ir_update", instr, stream[n +: IRW]);
    end else if (kind == 2) begin
      m_bsr_upd = stream[n +: BSRW];
      check_eq("bsr_update", bsr_update_data, m_bsr_upd);
    end else begin
      check_eq("bsr_hold", bsr_update_data, m_bsr_upd);
    end
    tck_cycle(1'b0, 1'($urandom));
  endtask

  task automatic scan_ir(input logic [IRW-1:0] op);
    scan(1'b1, IRW, {59'b0, op}, IRW, BSRW'($urandom));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    edge_def(ST_TLR,      ST_RTI,      ST_TLR);
    edge_def(ST_RTI,      ST_RTI,      ST_SEL_DR);
    edge_def(ST_SEL_DR,   ST_CAP_DR,   ST_SEL_IR);
    edge_def(ST_CAP_DR,   ST_SHIFT_DR, ST_EXIT1_DR);
    edge_def(ST_SHIFT_DR, ST_SHIFT_DR, ST_EXIT1_DR);
    edge_def(ST_EXIT1_DR, ST_PAUSE_DR, ST_UPD_DR);
    edge_def(ST_PAUSE_DR, ST_PAUSE_DR, ST_EXIT2_DR);
    edge_def(ST_EXIT2_DR, ST_SHIFT_DR, ST_UPD_DR);
    edge_def(ST_UPD_DR,   ST_RTI,      ST_SEL_DR);
    edge_def(ST_SEL_IR,   ST_CAP_IR,   ST_TLR);
    edge_def(ST_CAP_IR,   ST_SHIFT_IR, ST_EXIT1_IR);
    edge_def(ST_SHIFT_IR, ST_SHIFT_IR, ST_EXIT1_IR);
    edge_def(ST_EXIT1_IR, ST_PAUSE_IR, ST_UPD_IR);
    edge_def(ST_PAUSE_IR, ST_PAUSE_IR, ST_EXIT2_IR);
    edge_def(ST_EXIT2_IR, ST_SHIFT_IR, ST_UPD_IR);
    edge_def(ST_UPD_IR,   ST_RTI,      ST_SEL_DR);
    model_reset();

    // Reset values, then IDCODE readout straight after reset
    do_reset();
    tck_cycle(1'b0, 1'b0);
    scan(1'b0, 32, {$urandom, $urandom}, 32, BSRW'($urandom));

    // IR capture pattern, BYPASS load, 1-bit delayed DR
    scan_ir(5'b11111);
    check_eq("bypass_instr", instr, 5'b11111);
    scan(1'b0, 4, 64'b1101, 4, '0);

    // Five TMS=1 reach TLR from every state
    for (int s = 0; s < 16; s++) begin
      int unsigned cnt;
      cnt = 0;
      while (m_state != tap_state_e'(s) && cnt < 400) begin
        tck_cycle(1'($urandom), 1'($urandom));
        cnt++;
      end
      check_eq("walk_bound", cnt < 400, 1);
      check_eq("walk_reach", tap_state, s);
      repeat (5) tck_cycle(1'b1, 1'($urandom));
      check_eq("tlr_state", tap_state, ST_TLR);
      check_eq("tlr_instr", instr, 1);
    end
    do_reset();
    tck_cycle(1'b0, 1'b0);

    // PRELOAD / EXTEST / SAMPLE / INTEST
    scan_ir(5'd3);
    scan(1'b0, 7, 64'h55, 7, BSRW'($urandom));
    check_eq("preload_upd", bsr_update_data, 7'h55);
    scan_ir(5'd5);
    check_eq("extest_mode", bsr_test_mode, 1);
    check_eq("extest_upd", bsr_update_data, 7'h55);
    scan_ir(5'd2);
    scan(1'b0, 7, {$urandom, $urandom}, 7, 7'h2A);
    scan_ir(5'd4);
    check_eq("intest_flag", bsr_intest, 1);

    // User chain 1
    scan_ir(UBASE + 5'd1);
    check_eq("user_sel1", user_sel, 2'b10);
    scan(1'b0, 12, {$urandom, $urandom}, 5, BSRW'($urandom));

    // Undefined opcode acts as BYPASS
    scan_ir(5'b10110);
    scan(1'b0, 6, 64'b101101, 6, BSRW'($urandom));

    // Asynchronous reset in the middle of an EXTEST shift
    scan_ir(5'd3);
    scan(1'b0, 7, 64'h7F, 7, BSRW'($urandom));
    scan_ir(5'd5);
    bsr_capture_data = 7'h7F;
    tck_cycle(1'b1, 1'b1);
    tck_cycle(1'b0, 1'b1);
    tck_cycle(1'b0, 1'b1);
    repeat (3) tck_cycle(1'b0, 1'b1);
    check_eq("pre_reset_tdo", tdo, 1);
    check_eq("pre_reset_upd", bsr_update_data, 7'h7F);
    @(posedge tck);
    #5;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async");
    @(negedge tck);
    #5;
    rst_n = 1'b1;
    model_reset();
    tck_cycle(1'b0, 1'b0);

    // Randomized instruction / data scans
    for (int it = 0; it < 40; it++) begin
      logic [IRW-1:0] op;
      int unsigned    n;
      if ($urandom_range(0, 1) == 1) begin
        case ($urandom_range(0, 7))
          0: op = 5'd1;
          1: op = 5'd2;
          2: op = 5'd3;
          3: op = 5'd4;
          4: op = 5'd5;
          5: op = UBASE;
          6: op = UBASE + 5'd1;
          default: op = 5'b11111;
        endcase
      end else begin
        op = IRW'($urandom);
      end
      scan(1'b1, IRW, {59'b0, op}, $urandom_range(0, IRW), BSRW'($urandom));
      n = $urandom_range(1, 45);
      scan(1'b0, n, {$urandom, $urandom}, $urandom_range(0, n), BSRW'($urandom));
      repeat ($urandom_range(0, 2)) tck_cycle(1'b0, 1'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
